// File: rtl/lsu_axi4l_master_pkg.sv
// rtl/lsu_axi4l_master_pkg.sv - shared types, AXI response codes and helpers for the LSU AXI4-Lite master
package lsu_axi4l_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  // Ceiling log2, used to size the watchdog counter.
  function automatic int clogb2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Anything other than OKAY is reported to the core as an error.
  // EXOKAY has no meaning on AXI4-Lite, so it is treated as a failure too.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/lsu_axi4l_master_wdt.sv
// rtl/lsu_axi4l_master_wdt.sv - per-state watchdog counter that flags a stalled access
module lsu_axi4l_master_wdt
  import lsu_axi4l_master_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = clogb2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority; the owner always changes state on expiry, so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/lsu_axi4l_master.sv
// rtl/lsu_axi4l_master.sv - single-outstanding AXI4-Lite master bridging the core load/store unit
module lsu_axi4l_master
  import lsu_axi4l_master_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        wstrb_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              abort;
  logic              expire;
  logic              aw_hs;
  logic              w_hs;

  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q && m_axi_wready;

  lsu_axi4l_master_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_d != state_q),
    .run_i    (state_q != ST_IDLE),
    .expire_o (expire)
  );

  // Next-state and registered-output logic; a handshake on the expiry edge beats the abort.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          wstrb_d   = wstrb_i;
          busy_d    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (we_i) begin
            state_d   = ST_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_WRESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = resp_is_err(m_axi_bresp);
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RDATA: begin
        if (m_axi_rvalid && rready_q) begin
          rdata_d  = m_axi_rdata;
          rready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = resp_is_err(m_axi_rresp);
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rdata_d   = '0;
      done_d    = 1'b1;
      err_d     = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  // State and output registers; reset discards any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_lsu_axi4l_master.sv
// tb/tb_lsu_axi4l_master.sv - table-driven bench for the LSU AXI4-Lite master
module tb_lsu_axi4l_master;
  import lsu_axi4l_master_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int WIN = 22;
  localparam logic [7:0] NEVER = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [3:0]    wstrb_i;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  lsu_axi4l_master #(.TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Delays: aw/w/ar ready rises at cycle 1+dly; b/r valid rises at the given cycle; NEVER = silent.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] sdata;
    logic [7:0]  aw_dly, w_dly, b_cyc, ar_dly, r_cyc;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_aw, exp_w, exp_b, exp_ar, exp_r;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = RESP_OKAY;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = RESP_OKAY; m_axi_rdata = '0;
  endtask

  task automatic drive_slave(input vec_t v, input int c);
    m_axi_awready = (v.aw_dly != NEVER) && (c >= 1 + int'(v.aw_dly));
    m_axi_wready  = (v.w_dly  != NEVER) && (c >= 1 + int'(v.w_dly));
    m_axi_arready = (v.ar_dly != NEVER) && (c >= 1 + int'(v.ar_dly));
    m_axi_bvalid  = (v.b_cyc  != NEVER) && (c >= int'(v.b_cyc));
    m_axi_rvalid  = (v.r_cyc  != NEVER) && (c >= int'(v.r_cyc));
    m_axi_bresp   = v.resp;
    m_axi_rresp   = v.resp;
    m_axi_rdata   = v.sdata;
  endtask

  // Entered and left at posedge+1; request issued in cycle 0, outputs sampled on each negedge.
  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] m_aw, m_w, m_b, m_ar, m_r, m_done, m_err, m_busy, rd;
    logic        payload_ok;
    m_aw = '0; m_w = '0; m_b = '0; m_ar = '0; m_r = '0;
    m_done = '0; m_err = '0; m_busy = '0; rd = 32'hFFFF_FFFF; payload_ok = 1'b1;
    we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; wstrb_i = v.wstrb;
    for (int c = 0; c < WIN; c++) begin
      req_i = (c == 0);
      drive_slave(v, c);
      @(negedge clk);
      m_aw[c] = m_axi_awvalid; m_w[c] = m_axi_wvalid; m_b[c] = m_axi_bready;
      m_ar[c] = m_axi_arvalid; m_r[c] = m_axi_rready;
      m_done[c] = done_o; m_err[c] = err_o; m_busy[c] = busy_o;
      if (done_o) rd = rdata_o;
      if (m_axi_awvalid && (m_axi_awaddr !== v.addr || m_axi_awprot !== 3'b000)) payload_ok = 1'b0;
      if (m_axi_wvalid && (m_axi_wdata !== v.wdata || m_axi_wstrb !== v.wstrb)) payload_ok = 1'b0;
      if (m_axi_arvalid && (m_axi_araddr !== v.addr || m_axi_arprot !== 3'b000)) payload_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    req_i = 1'b0;
    slave_idle();
    check($sformatf("v%0d done", idx), m_done, 32'd1 << v.exp_done);
    check($sformatf("v%0d err", idx), m_err, v.exp_err ? (32'd1 << v.exp_done) : 32'd0);
    check($sformatf("v%0d busy", idx), m_busy, ((32'd1 << v.exp_done) - 32'd1) & ~32'd1);
    check($sformatf("v%0d awvalid", idx), m_aw, v.exp_aw);
    check($sformatf("v%0d wvalid", idx), m_w, v.exp_w);
    check($sformatf("v%0d bready", idx), m_b, v.exp_b);
    check($sformatf("v%0d arvalid", idx), m_ar, v.exp_ar);
    check($sformatf("v%0d rready", idx), m_r, v.exp_r);
    check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d payload", idx), 32'(payload_ok), 32'd1);
  endtask

  initial begin
    // we, addr, wdata, wstrb, resp, sdata, aw, w, b, ar, r, done, err, rdata, awm, wm, bm, arm, rm
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, RESP_OKAY, 32'h0, 8'd0, 8'd0, 8'd0, NEVER, NEVER,
                 3, 1'b0, 32'h0, 32'h2, 32'h2, 32'h4, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'h01020304, 4'h5, RESP_OKAY, 32'h0, 8'd3, 8'd0, 8'd0, NEVER, NEVER,
                 6, 1'b0, 32'h0, 32'h1E, 32'h2, 32'h20, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0800_0004, 32'h0, 4'h0, RESP_OKAY, 32'h12345678, NEVER, NEVER, NEVER, 8'd0, 8'd4,
                 5, 1'b0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h2, 32'h1C};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, RESP_SLVERR, 32'hCAFEF00D, NEVER, NEVER, NEVER, 8'd0, 8'd0,
                 3, 1'b1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h2, 32'h4};
    vecs[4]  = '{1'b1, 32'h0000_0044, 32'h55AA55AA, 4'h8, RESP_DECERR, 32'h0, 8'd1, 8'd2, 8'd6, NEVER, NEVER,
                 7, 1'b1, 32'hCAFEF00D, 32'h6, 32'hE, 32'h70, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0048, 32'h0, 4'h0, RESP_DECERR, 32'h0BADF00D, NEVER, NEVER, NEVER, 8'd2, 8'd0,
                 5, 1'b1, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 32'hE, 32'h10};
    vecs[6]  = '{1'b0, 32'h0000_004C, 32'h0, 4'h0, RESP_OKAY, 32'h77777777, NEVER, NEVER, NEVER, NEVER, NEVER,
                 17, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1FFFE, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0050, 32'h0, 4'h0, RESP_OKAY, 32'hA5A50001, NEVER, NEVER, NEVER, 8'd0, 8'd17,
                 18, 1'b0, 32'hA5A50001, 32'h0, 32'h0, 32'h0, 32'h2, 32'h3FFFC};
    vecs[8]  = '{1'b1, 32'h0000_0054, 32'h11223344, 4'hF, RESP_OKAY, 32'h0, 8'd0, 8'd0, NEVER, NEVER, NEVER,
                 18, 1'b1, 32'h0, 32'h2, 32'h2, 32'h3FFFC, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0058, 32'h0, 4'h0, RESP_OKAY, 32'h5A5A0002, NEVER, NEVER, NEVER, 8'd15, 8'd0,
                 18, 1'b0, 32'h5A5A0002, 32'h0, 32'h0, 32'h0, 32'h1FFFE, 32'h20000};
    vecs[10] = '{1'b1, 32'h0000_005C, 32'h99887766, 4'h1, RESP_OKAY, 32'h0, NEVER, 8'd0, 8'd0, NEVER, NEVER,
                 17, 1'b1, 32'h0, 32'h1FFFE, 32'h2, 32'h0, 32'h0, 32'h0};

    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
    slave_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ctrl", 32'({busy_o, done_o, err_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready}), 32'h0);
    check("reset rdata", rdata_o, 32'h0);
    check("reset addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Read with SLVERR, followed by a write requested in the done cycle.
    we_i = 1'b0; addr_i = 32'h0000_0100; req_i = 1'b1;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rresp = RESP_SLVERR; m_axi_rdata = 32'h11112222;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = RESP_OKAY;
    @(posedge clk); #1; req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0200; wdata_i = 32'h33334444; wstrb_i = 4'h3;
    @(negedge clk);
    check("b2b rd done/err", 32'({done_o, err_o, busy_o}), 32'h6);
    check("b2b rd rdata", rdata_o, 32'h11112222);
    @(posedge clk); #1; req_i = 1'b0;
    @(negedge clk);
    check("b2b wr accepted", 32'({busy_o, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'hE);
    check("b2b wr addr", m_axi_awaddr, 32'h0000_0200);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b wr bready", 32'({m_axi_bready, done_o}), 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b wr done", 32'({done_o, err_o, busy_o}), 32'h4);
    @(posedge clk); #1;
    slave_idle();

    // Asynchronous reset while waiting in WRESP.
    we_i = 1'b1; addr_i = 32'h0000_0300; wdata_i = 32'h0; wstrb_i = 4'hF; req_i = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(posedge clk); #1; req_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("wresp before rst", 32'({m_axi_bready, busy_o}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async rst outs", 32'({busy_o, done_o, err_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                 m_axi_arvalid, m_axi_rready}), 32'h0);
    slave_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_axi4l_master.md
Name: lsu_axi4l_master

Overview:
AXI4-Lite master bridge between the core's load/store unit and the system AXI4-Lite interconnect; the initiator end of the slave ports the memories (iram, dram, peripherals) expose. It accepts one single-beat request at a time on a simple valid/busy interface and drives the AW/W/B or AR/R channel sequence. It returns read data, completion and error status, with a watchdog so a dead slave cannot hang the core.

Parameters:
TIMEOUT, 256, cycles allowed in any wait state before the access is aborted with an error; must be ≥ 2.
ADDR_W, 32, AXI address width; same as `MemAddrBus.
DATA_W, 32, AXI data width; same as `MemBus.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req_i  in  1  request strobe; sampled only while busy_o=0
we_i  in  1  1=write, 0=read
addr_i  in  ADDR_W  byte address
wdata_i  in  DATA_W  write data
wstrb_i  in  4  write byte strobes
busy_o  out  1  access in flight; core holds the pipeline
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle pulse, coincident with done_o; SLVERR/DECERR or timeout
rdata_o  out  DATA_W  read data, valid from the done_o cycle until the next read completes
m_axi_awaddr/awprot/awvalid  out  ADDR_W/3/1; m_axi_awready  in  1
m_axi_wdata/wstrb/wvalid  out  DATA_W/4/1; m_axi_wready  in  1
m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1
m_axi_araddr/arprot/arvalid  out  ADDR_W/3/1; m_axi_arready  in  1
m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1

Behaviour:
- Reset values: all outputs 0; state IDLE. A reset mid-access drops every valid/ready immediately and discards the access.
- All outputs are registered. awprot and arprot are constant 3'b000.
- States: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE, req_i=1:
  - Latch address, data and strobes; set busy_o on the next edge.
  - we_i=1: go to WADDR and raise awvalid and wvalid together.
  - we_i=0: go to RADDR and raise arvalid.
- WADDR: AW and W handshakes are tracked independently with flags aw_done/w_done.
  - Each valid drops the cycle after its own handshake (valid & ready). Slaves that accept both in one cycle are supported.
  - When both flags are set, go to WRESP and raise bready.
- WRESP:
  - bvalid is ignored in every state except WRESP; slaves may hold bvalid constantly high.
  - On bvalid & bready: drop bready, pulse done_o, set err_o = (bresp != 2'b00), return to IDLE, clear busy_o.
- RADDR: on arready, drop arvalid, go to RDATA and raise rready.
- RDATA: on rvalid & rready: capture rdata, pulse done_o, set err_o = (rresp != 2'b00), drop rready, return to IDLE.
- Latency with a zero-wait slave:
  - Write: req cycle 0; AW+W handshake cycle 1; B handshake cycle 2; done_o cycle 3.
  - Read: AR handshake cycle 1; R handshake cycle 2; done_o cycle 3.
- Back-to-back: busy_o is 0 in the done_o cycle; a new req_i in that cycle is accepted.
- Watchdog:
  - Counter is cleared on every state entry and increments in each non-IDLE cycle.
  - Reaching TIMEOUT-1 without completing: force all valid/ready low, pulse done_o and err_o, rdata_o=0, return to IDLE.
  - Counter width is clog2(TIMEOUT); it never wraps because it is cleared on abort.
- A handshake arriving on the same edge as the timeout wins: the access completes normally.
- req_i while busy_o=1 is ignored; the core must hold it.

Decomposition:
- AXI resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) and the state encodings go in defines.v alongside `MemAddrBus/`MemBus.
- The watchdog counter is a natural sub-module, axi_wdt (inputs clear, run; output expire).
- clog2 uses the local clogb2 function.

Test Plan:
- Write 0x0000_0010 ← 0xDEADBEEF, wstrb 4'hF, slave with ready tied 1 and bvalid constantly 1 → AW+W handshake cycle 1, bready only in cycle 2, done_o cycle 3, err_o=0.
- AW ready delayed 3 cycles, W ready immediate → wvalid drops after cycle 1, awvalid held with a stable address until cycle 4, B handled afterwards, done_o once.
- Read 0x0800_0004, slave returns 0x12345678 after 2-cycle rvalid delay → rdata_o=0x12345678 at done_o, err_o=0, rready low outside RDATA.
- Read with rresp=2'b10 → done_o and err_o pulse together; a subsequent req_i in the same cycle is accepted.
- Silent slave (no ready ever), TIMEOUT=16 → abort 16 cycles after entering RADDR, arvalid low, done_o=err_o=1, busy_o=0.
- Assert rst_n=0 during WRESP → all valids, bready and busy_o 0 asynchronously; first request after reset completes normally.
